// File: rtl/fwd_hazard_pkg.sv
// rtl/fwd_hazard_pkg.sv - shared types, constants and forwarding-select helper for fwd_hazard_unit
package fwd_hazard_pkg;

  localparam int FWD_RF  = 0;
  // Helper operates on zero-padded vectors so one function serves any REG_AW/NSTG up to these limits.
  localparam int MAX_AW  = 8;
  localparam int MAX_STG = 8;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} md_state_t;

  // Youngest matching stage wins: scan oldest to youngest so younger matches overwrite.
  function automatic logic [3:0] fwd_sel_calc(
    input logic [MAX_AW-1:0]         src,
    input logic [MAX_STG*MAX_AW-1:0] rd_vec,
    input logic [MAX_STG-1:0]        regwrite,
    input int                        nstg
  );
    logic [3:0]        sel;
    logic [MAX_AW-1:0] rd_i;
    sel = 4'(FWD_RF);
    for (int i = MAX_STG - 1; i >= 0; i--) begin
      rd_i = rd_vec[i*MAX_AW +: MAX_AW];
      if (i < nstg && regwrite[i] && rd_i != '0 && rd_i == src) sel = 4'(nstg - i);
    end
    return sel;
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_md_interlock.sv
// rtl/fwd_hazard_unit_md_interlock.sv - multi-cycle multiply/divide busy interlock and misuse flag
module md_interlock
  import fwd_hazard_pkg::*;
#(
  parameter int MD_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic err
);

  localparam int CW = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;

  md_state_t     state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= BUSY;
            cnt   <= CW'(MD_LAT - 1);
          end
        end
        BUSY: begin
          // A second issue while busy is dropped, not restarted.
          if (start) err <= 1'b1;
          if (cnt == CW'(1)) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign busy = (state == BUSY);

endmodule

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - EX operand forwarding, load-use and mult/div stall generation with stall counter
module fwd_hazard_unit
  import fwd_hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int NSRC   = 2,
  parameter int NSTG   = 2,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 16,
  parameter int SEL_W  = $clog2(NSTG + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NSRC*REG_AW-1:0] idex_src,
  input  logic [NSRC*REG_AW-1:0] ifid_src,
  input  logic [REG_AW-1:0]      idex_rd,
  input  logic                   idex_regwrite,
  input  logic                   idex_memread,
  input  logic [NSTG*REG_AW-1:0] stg_rd,
  input  logic [NSTG-1:0]        stg_regwrite,
  input  logic                   md_start,
  input  logic                   ifid_md_use,
  output logic [NSRC*SEL_W-1:0]  fwd_sel,
  output logic                   stall,
  output logic                   flush_idex,
  output logic                   md_busy,
  output logic                   md_err,
  output logic [CNT_W-1:0]       stall_cnt
);

  logic [MAX_STG*MAX_AW-1:0] rd_pad;
  logic [MAX_STG-1:0]        regwrite_pad;
  logic [NSRC-1:0]           lu_hit;
  logic                      lu;

  always_comb begin
    rd_pad = '0;
    for (int i = 0; i < NSTG; i++) rd_pad[i*MAX_AW +: MAX_AW] = MAX_AW'(stg_rd[i*REG_AW +: REG_AW]);
  end
  assign regwrite_pad = MAX_STG'(stg_regwrite);

  for (genvar j = 0; j < NSRC; j++) begin : g_src
    logic [MAX_AW-1:0] src_pad;
    assign src_pad = MAX_AW'(idex_src[j*REG_AW +: REG_AW]);
    assign fwd_sel[j*SEL_W +: SEL_W] =
      rst ? SEL_W'(FWD_RF) : SEL_W'(fwd_sel_calc(src_pad, rd_pad, regwrite_pad, NSTG));
    assign lu_hit[j] = (ifid_src[j*REG_AW +: REG_AW] == idex_rd);
  end

  assign lu         = idex_memread && idex_regwrite && (idex_rd != '0) && (|lu_hit);
  assign stall      = !rst && (lu || (md_busy && ifid_md_use));
  assign flush_idex = stall;

  md_interlock #(.MD_LAT(MD_LAT)) u_md (
    .clk   (clk),
    .rst   (rst),
    .start (md_start),
    .busy  (md_busy),
    .err   (md_err)
  );

  always_ff @(posedge clk) begin
    if (rst) stall_cnt <= '0;
    else if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the EX-stage forwarding unit. Generalised to NSRC source operands and NSTG forwarding stages.
- Adds load-use stall/bubble generation and a multi-cycle multiply/divide (HI/LO) interlock FSM.
- Adds a saturating stall-cycle performance counter.
- Sits beside the ID/EX register. Drives the EX operand muxes, PC/IF-ID write enables and the ID/EX bubble.

Parameters:
- REG_AW, 5, register address width.
- NSRC, 2, source operands per instruction (rs, rt, ...).
- NSTG, 2, forwarding stages after EX; stage 0 = youngest (EX/MEM), stage NSTG-1 = oldest (MEM/WB).
- MD_LAT, 4, multiply/divide latency in cycles (>=2).
- CNT_W, 16, stall counter width.
- SEL_W, $clog2(NSTG+1), derived forwarding-select width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- idex_src  in  NSRC*REG_AW  ID/EX source register numbers; operand j at [j*REG_AW +: REG_AW]
- ifid_src  in  NSRC*REG_AW  IF/ID source register numbers
- idex_rd  in  REG_AW  ID/EX destination
- idex_regwrite  in  1  ID/EX writes a register
- idex_memread  in  1  ID/EX is a load
- stg_rd  in  NSTG*REG_AW  destination per forwarding stage
- stg_regwrite  in  NSTG  RegWrite per forwarding stage
- md_start  in  1  ID/EX issues mult/div this cycle
- ifid_md_use  in  1  IF/ID reads HI/LO or is a mult/div
- fwd_sel  out  NSRC*SEL_W  per-operand select: 0 = register file, NSTG-i = stage i
- stall  out  1  hold PC and IF/ID
- flush_idex  out  1  insert bubble into ID/EX
- md_busy  out  1  mult/div in flight
- md_err  out  1  sticky: md_start while busy
- stall_cnt  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Forwarding (combinational), per operand j:
  - Youngest matching stage i wins: stg_regwrite[i] && stg_rd[i]!=0 && stg_rd[i]==idex_src[j] gives fwd_sel[j]=NSTG-i.
  - No match gives 0.
  - With NSTG=2: EX/MEM = 2'b10, MEM/WB = 2'b01.
  - Register 0 is never forwarded.
  - fwd_sel is always fully assigned; there is no latched previous value.
  - Forced to 0 while rst=1.
- Load-use (combinational):
  - lu = idex_memread && idex_regwrite && idex_rd!=0 && idex_rd matches any ifid_src[j].
  - lu gives stall=1 and flush_idex=1 in the same cycle.
- Mult/div FSM (registered), states IDLE, BUSY:
  - IDLE: md_start loads cnt=MD_LAT-1, goes to BUSY, md_busy=1 from the next cycle.
  - BUSY: cnt decrements each cycle. When cnt==1 the next state is IDLE. md_busy is high for exactly MD_LAT-1 cycles after the issue cycle.
  - BUSY && ifid_md_use gives stall=1 and flush_idex=1.
  - md_start while BUSY: ignored (no reload) and md_err set. md_err clears only on rst.
- Combined stall:
  - stall = lu | (md_busy & ifid_md_use); flush_idex = stall.
  - Simultaneous causes produce a single stall.
- stall_cnt:
  - Increments by 1 on each clock where stall=1.
  - Saturates at 2^CNT_W-1; never wraps.
- Reset:
  - md_busy=0, md_err=0, stall_cnt=0, FSM=IDLE, cnt=0, stall=0, flush_idex=0, fwd_sel=0.
  - rst mid-BUSY aborts immediately.
  - md_start is ignored in the rst cycle.
- Latency: forwarding and stall are 0-cycle combinational; md_busy is 1-cycle registered.

Decomposition:
- Package fwd_hazard_pkg:
  - FWD_RF=0 select constant.
  - md_state_t enum {IDLE, BUSY}.
  - function fwd_sel_calc(src, rd vector, regwrite vector).
- One sub-module: md_interlock (FSM, counter, md_busy, md_err).
- Forwarding and load-use logic stay in the top as generate loops over NSRC.

Test Plan:
- Double hazard: idex_src rs=5, both stages rd=5 with regwrite=11 -> fwd_sel[rs]=2'b10; drop stg_regwrite[0] -> 2'b01.
- Register zero: stg_rd[0]=0, regwrite=1, idex_src=0 -> fwd_sel=0, no stall; load with idex_rd=0 and ifid_src=0 -> stall=0.
- Load-use: idex_memread=1, idex_rd=8, ifid_src rt=8 -> stall=1 and flush_idex=1 for that cycle; stall_cnt 0->1.
- Mult/div, MD_LAT=4: md_start pulse -> md_busy high for 3 cycles; ifid_md_use=1 throughout -> 3 stall cycles, stall_cnt=3.
- Misuse and reset: md_start again during BUSY -> md_err=1, busy length unchanged; rst in 2nd BUSY cycle -> next cycle md_busy=0, md_err=0, stall_cnt=0.
- Saturation: CNT_W=4, hold stall for 20 cycles -> stall_cnt stays at 15.
